id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline stage of the pipelined ARMv8 core: registers the decoded instruction, resolves operand forwarding from EX/MEM and MEM/WB, and drives the 64-bit ALU's `in1`, `in2` and `control` inputs. It also detects load-use hazards, stalls IF/ID for one cycle and injects a bubble into EX. Branch flush from later stages clears the register to a bubble.

## Interface
Parameters
- `XLEN`, 64: datapath width.
- `REG_ZR`, 31: register index never forwarded (XZR).

Ports
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `id_valid` in 1: ID slot holds a real instruction.
- `id_rn`, `id_rm`, `id_rd` in 5 each: source and destination register indices.
- `id_rn_used`, `id_rm_used` in 1 each: source is actually read.
- `id_rd_wr` in 1: instruction writes `rd`.
- `id_is_load` in 1: instruction is a load.
- `id_rn_data`, `id_rm_data` in XLEN each: register-file read data.
- `id_imm` in XLEN: extended immediate or shift amount.
- `id_use_imm` in 1: ALU `in2` takes the immediate instead of `rm`.
- `id_alu_control` in 4: ALU opcode.
- `flush` in 1: kill the instruction being captured.
- `exmem_rd` in 5, `exmem_wr` in 1, `exmem_data` in XLEN: EX/MEM forward source.
- `memwb_rd` in 5, `memwb_wr` in 1, `memwb_data` in XLEN: MEM/WB forward source.
- `id_stall` out 1: hold PC and IF/ID this cycle.
- `ex_in1`, `ex_in2` out XLEN: ALU operands.
- `ex_control` out 4: ALU opcode.
- `ex_valid`, `ex_rd_wr`, `ex_is_load` out 1 each: EX-slot status.
- `ex_rd` out 5: EX destination register.
- `ex_store_data` out XLEN: forwarded `rm` value, used by stores.

## Operation
Registered state
- ID/EX register holds: `valid`, `rn`, `rm`, `rd`, `rn_used`, `rm_used`, `rd_wr`, `is_load`, `rn_data`, `rm_data`, `imm`, `use_imm`, `control`.

Hazard detection (combinational, from the ID inputs and the registered EX slot)
- `id_stall` = `ex_valid & ex_is_load & ex_rd_wr & ex_rd != REG_ZR & id_valid & ((id_rn_used & id_rn == ex_rd) | (id_rm_used & id_rm == ex_rd))`.
- `flush` forces `id_stall` = 0.

Register update at the clock edge, in priority order
- `reset` or `flush`: load a bubble. All fields are 0, so `valid`, `rd_wr` and `is_load` are 0 and `control` is 4'b0000.
- `id_stall`: load a bubble. IF/ID holds upstream, so the stalled instruction is re-presented and captured on the next cycle.
- Otherwise: capture the ID inputs. `valid` is set to `id_valid`; `rd_wr` and `is_load` are ANDed with `id_valid`.

Forwarding (combinational on registered `rn`/`rm`)
- Operand `fwdN` is `exmem_data` if `exmem_wr` and `exmem_rd == src` and `src != REG_ZR`.
- Else it is `memwb_data` if `memwb_wr` and `memwb_rd == src` and `src != REG_ZR`.
- Else it is the registered register-file data.
- EX/MEM has priority over MEM/WB.
- A source of `REG_ZR` is never forwarded.

Outputs
- `ex_in1` = `fwd_rn`.
- `ex_in2` = `use_imm ? imm : fwd_rm`. For LSL/LSR the immediate carries the shift amount, which the ALU reads from `in2[31:0]`.
- `ex_store_data` = `fwd_rm`, regardless of `use_imm`.
- `ex_control`, `ex_rd`, `ex_rd_wr`, `ex_is_load`, `ex_valid` come directly from the register.

## Timing
- Latency: one cycle from ID capture to valid ALU inputs. Forwarding adds no cycle.
- Reset values: all registered outputs are 0. `ex_in1`, `ex_in2` and `ex_store_data` are 0 unless a forward source matches register 0. `id_stall` is 0.
- A load-use hazard costs exactly one stall cycle. On the next cycle the load sits in MEM and its data reaches EX via the MEM/WB path one cycle later; `id_stall` drops because `ex_valid` is now 0.
- `flush` and stall in the same cycle: flush wins, a bubble is loaded and `id_stall` = 0.
- `reset` in the middle of a stall clears everything. There is no residual stall.
- Back-to-back loads to the same `rd`: the second one stalls only when it consumes that `rd`.
- Bubbles never forward: the bubble's `rd_wr` = 0 propagates downstream.

## Structure
- A shared package `armv8_pkg` holds:
  - ALU control constants: `ALU_AND` 0000, `ALU_ORR` 0001, `ALU_ADD` 0010, `ALU_LSL` 0011, `ALU_SUB` 0110, `ALU_PASSB` 0111, `ALU_EOR` 1001, `ALU_LSR` 1011.
  - `REG_ZR`.
  - A packed ID/EX struct typedef.
- Sub-module `fwd_mux`, instantiated twice (`rn`, `rm`):
  - Inputs: `src`, the registered data, and both forward-source triples.
  - Output: the selected XLEN data.

## Test plan
- Reset, then idle: all `ex_*` outputs are 0 and `id_stall` = 0.
- ADD x1=5, x2=7, `id_use_imm`=0: one cycle later `ex_in1`=5, `ex_in2`=7, `ex_control`=0010, `ex_valid`=1.
- Forward priority: EX `rn`=3, `exmem_rd`=3 with data 0xAA, `memwb_rd`=3 with data 0xBB, both writes set → `ex_in1`=0xAA. Drop `exmem_wr` → `ex_in1`=0xBB.
- XZR: `rn`=31, `exmem_rd`=31, `exmem_wr`=1 → `ex_in1` equals the registered `rn_data`.
- Load-use: LDR x4 in EX, ID instruction uses `rm`=4 → `id_stall`=1 for exactly one cycle. EX then shows a bubble with `ex_valid`=0; the next cycle captures the instruction with `memwb_data` forwarded into `ex_in2`.
- `flush` asserted together with a load-use stall → `id_stall`=0 and the next EX slot is a bubble. `reset` during a stall gives all-zero outputs on the next cycle.

Source files
------------

// File: rtl/armv8_pkg.sv
// armv8_pkg: shared definitions for the ARMv8 pipeline.
//   - datapath width and the zero-register index
//   - ALU control encodings
//   - packed ID/EX pipeline register layout
package armv8_pkg;

  localparam int         XLEN   = 64;
  localparam logic [4:0] REG_ZR = 5'd31;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_LSL   = 4'b0011;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_EOR   = 4'b1001;
  localparam logic [3:0] ALU_LSR   = 4'b1011;

  // An all-zero value of this struct is a bubble.
  typedef struct packed {
    logic            valid;
    logic [4:0]      rn;
    logic [4:0]      rm;
    logic [4:0]      rd;
    logic            rn_used;
    logic            rm_used;
    logic            rd_wr;
    logic            is_load;
    logic [XLEN-1:0] rn_data;
    logic [XLEN-1:0] rm_data;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic [3:0]      control;
  } idex_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_if: bundle of the ID/EX stage signals.
//   slave  : view of the id_ex_stage (decode/forward inputs, EX outputs)
//   master : view of whatever drives the stage (decode logic, testbench)
interface id_ex_if #(parameter int XLEN = 64);
  logic            id_valid;
  logic [4:0]      id_rn, id_rm, id_rd;
  logic            id_rn_used, id_rm_used;
  logic            id_rd_wr, id_is_load;
  logic [XLEN-1:0] id_rn_data, id_rm_data, id_imm;
  logic            id_use_imm;
  logic [3:0]      id_alu_control;
  logic            flush;
  logic [4:0]      exmem_rd;
  logic            exmem_wr;
  logic [XLEN-1:0] exmem_data;
  logic [4:0]      memwb_rd;
  logic            memwb_wr;
  logic [XLEN-1:0] memwb_data;

  logic            id_stall;
  logic [XLEN-1:0] ex_in1, ex_in2, ex_store_data;
  logic [3:0]      ex_control;
  logic            ex_valid, ex_rd_wr, ex_is_load;
  logic [4:0]      ex_rd;

  modport slave (
    input  id_valid, id_rn, id_rm, id_rd, id_rn_used, id_rm_used, id_rd_wr,
           id_is_load, id_rn_data, id_rm_data, id_imm, id_use_imm,
           id_alu_control, flush, exmem_rd, exmem_wr, exmem_data,
           memwb_rd, memwb_wr, memwb_data,
    output id_stall, ex_in1, ex_in2, ex_store_data, ex_control, ex_valid,
           ex_rd_wr, ex_is_load, ex_rd
  );

  modport master (
    output id_valid, id_rn, id_rm, id_rd, id_rn_used, id_rm_used, id_rd_wr,
           id_is_load, id_rn_data, id_rm_data, id_imm, id_use_imm,
           id_alu_control, flush, exmem_rd, exmem_wr, exmem_data,
           memwb_rd, memwb_wr, memwb_data,
    input  id_stall, ex_in1, ex_in2, ex_store_data, ex_control, ex_valid,
           ex_rd_wr, ex_is_load, ex_rd
  );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: operand forwarding select for one source register.
//   src_i                     : registered source register index
//   reg_data_i                : registered register-file read data
//   exmem_{rd,wr,data}_i      : EX/MEM forward source (highest priority)
//   memwb_{rd,wr,data}_i      : MEM/WB forward source
//   data_o                    : selected operand
module fwd_mux #(
  parameter int         XLEN   = 64,
  parameter logic [4:0] REG_ZR = 5'd31
) (
  input  logic [4:0]      src_i,
  input  logic [XLEN-1:0] reg_data_i,
  input  logic [4:0]      exmem_rd_i,
  input  logic            exmem_wr_i,
  input  logic [XLEN-1:0] exmem_data_i,
  input  logic [4:0]      memwb_rd_i,
  input  logic            memwb_wr_i,
  input  logic [XLEN-1:0] memwb_data_i,
  output logic [XLEN-1:0] data_o
);

  logic src_fwd_ok;
  assign src_fwd_ok = (src_i != REG_ZR);

  always_comb begin
    data_o = reg_data_i;
    if (src_fwd_ok && exmem_wr_i && (exmem_rd_i == src_i)) begin
      data_o = exmem_data_i;
    end else if (src_fwd_ok && memwb_wr_i && (memwb_rd_i == src_i)) begin
      data_o = memwb_data_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection and
// operand forwarding into the ALU.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : id_ex_if slave - ID inputs, flush, forward sources,
//           id_stall and the ex_* ALU/EX-slot outputs
module id_ex_stage #(
  parameter int         XLEN   = 64,
  parameter logic [4:0] REG_ZR = 5'd31
) (
  input logic     clk,
  input logic     reset,
  id_ex_if.slave  bus
);
  import armv8_pkg::*;

  idex_t           idex_q, idex_d;
  logic            stall;
  logic [XLEN-1:0] fwd_rn, fwd_rm;

  // A load in EX whose result is consumed by the instruction in ID cannot
  // be forwarded in time; hold ID one cycle and send a bubble instead.
  always_comb begin
    stall = idex_q.valid && idex_q.is_load && idex_q.rd_wr &&
            (idex_q.rd != REG_ZR) && bus.id_valid &&
            ((bus.id_rn_used && (bus.id_rn == idex_q.rd)) ||
             (bus.id_rm_used && (bus.id_rm == idex_q.rd))) &&
            !bus.flush;
  end

  always_comb begin
    idex_d = '0;
    if (!bus.flush && !stall) begin
      idex_d.valid   = bus.id_valid;
      idex_d.rn      = bus.id_rn;
      idex_d.rm      = bus.id_rm;
      idex_d.rd      = bus.id_rd;
      idex_d.rn_used = bus.id_rn_used;
      idex_d.rm_used = bus.id_rm_used;
      idex_d.rd_wr   = bus.id_rd_wr & bus.id_valid;
      idex_d.is_load = bus.id_is_load & bus.id_valid;
      idex_d.rn_data = bus.id_rn_data;
      idex_d.rm_data = bus.id_rm_data;
      idex_d.imm     = bus.id_imm;
      idex_d.use_imm = bus.id_use_imm;
      idex_d.control = bus.id_alu_control;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) idex_q <= '0;
    else       idex_q <= idex_d;
  end

  fwd_mux #(.XLEN(XLEN), .REG_ZR(REG_ZR)) u_fwd_rn (
    .src_i        (idex_q.rn),
    .reg_data_i   (idex_q.rn_data),
    .exmem_rd_i   (bus.exmem_rd),
    .exmem_wr_i   (bus.exmem_wr),
    .exmem_data_i (bus.exmem_data),
    .memwb_rd_i   (bus.memwb_rd),
    .memwb_wr_i   (bus.memwb_wr),
    .memwb_data_i (bus.memwb_data),
    .data_o       (fwd_rn)
  );

  fwd_mux #(.XLEN(XLEN), .REG_ZR(REG_ZR)) u_fwd_rm (
    .src_i        (idex_q.rm),
    .reg_data_i   (idex_q.rm_data),
    .exmem_rd_i   (bus.exmem_rd),
    .exmem_wr_i   (bus.exmem_wr),
    .exmem_data_i (bus.exmem_data),
    .memwb_rd_i   (bus.memwb_rd),
    .memwb_wr_i   (bus.memwb_wr),
    .memwb_data_i (bus.memwb_data),
    .data_o       (fwd_rm)
  );

  assign bus.id_stall      = stall;
  assign bus.ex_in1        = fwd_rn;
  // Shift ops carry the shift amount in the immediate; the ALU reads in2[31:0].
  assign bus.ex_in2        = idex_q.use_imm ? idex_q.imm : fwd_rm;
  assign bus.ex_store_data = fwd_rm;
  assign bus.ex_control    = idex_q.control;
  assign bus.ex_valid      = idex_q.valid;
  assign bus.ex_rd_wr      = idex_q.rd_wr;
  assign bus.ex_is_load    = idex_q.is_load;
  assign bus.ex_rd         = idex_q.rd;

endmodule
